// File: rtl/onehot_dec_pkg.sv
// Shared widths, types and mask-population states for the streaming 3-to-8 decoder.
// Also used by the arbiter bench models.
package onehot_dec_pkg;

  localparam int CODE_W    = 3;
  localparam int NUM_LINES = 1 << CODE_W;

  typedef logic [CODE_W-1:0]    code_t;
  typedef logic [NUM_LINES-1:0] line_t;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } mask_state_e;

endpackage

// File: rtl/code_to_onehot.sv
// Combinational line-index to one-hot decode, the inverse of the priority encoder.
module code_to_onehot
  import onehot_dec_pkg::*;
(
  input  logic [CODE_W-1:0]    code,
  output logic [NUM_LINES-1:0] onehot
);

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/onehot_decoder_stream.sv
// Streaming 3-to-8 decoder with a registered output beat and an accumulated line mask
// that reports duplicates and full coverage.
module onehot_decoder_stream
  import onehot_dec_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CODE_W-1:0]    in_code,
  input  logic                 in_accum,
  input  logic                 clr,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NUM_LINES-1:0] out_onehot,
  output logic [NUM_LINES-1:0] out_mask,
  output logic                 out_dup,
  output logic                 out_full
);

  logic                 accept;
  logic [NUM_LINES-1:0] onehot;
  logic [NUM_LINES-1:0] mask_q;
  logic [NUM_LINES-1:0] mask_d;
  logic                 dup_d;
  mask_state_e          state_q;
  mask_state_e          state_d;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_mask = mask_q;
  assign out_full = (state_q == FULL);

  code_to_onehot u_decode (
    .code   (in_code),
    .onehot (onehot)
  );

  // A clear that coincides with a beat is applied first, so the beat lands on an empty mask.
  always_comb begin
    mask_d  = mask_q;
    state_d = state_q;
    dup_d   = 1'b0;
    if (accept) begin
      if (clr || !in_accum) begin
        mask_d = onehot;
      end else begin
        mask_d = mask_q | onehot;
      end
      dup_d   = in_accum && !clr && mask_q[in_code];
      state_d = (&mask_d) ? FULL : PARTIAL;
    end else if (clr) begin
      mask_d  = '0;
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q  <= '0;
      state_q <= EMPTY;
    end else begin
      mask_q  <= mask_d;
      state_q <= state_d;
    end
  end

  // Output beat register; data holds after a consume so only out_valid drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_onehot <= '0;
      out_dup    <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_onehot <= onehot;
      out_dup    <= dup_d;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_onehot_decoder_stream.sv
// Directed bench for onehot_decoder_stream: sweep, accumulate, clear, duplicate,
// backpressure and mid-stream reset, each step checked against hand-computed values.
module tb_onehot_decoder_stream;
  import onehot_dec_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_code;
  logic       in_accum;
  logic       clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_onehot;
  logic [7:0] out_mask;
  logic       out_dup;
  logic       out_full;

  int vectors;
  int miscompares;

  onehot_decoder_stream dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_code    (in_code),
    .in_accum   (in_accum),
    .clr        (clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_onehot (out_onehot),
    .out_mask   (out_mask),
    .out_dup    (out_dup),
    .out_full   (out_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one cycle of inputs, then returns 1ns after the edge that consumed them.
  task automatic applyStimulus(input logic v, input logic [2:0] code, input logic accum,
                               input logic c, input logic rdy);
    in_valid  = v;
    in_code   = code;
    in_accum  = accum;
    clr       = c;
    out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    logic [7:0] exp_mask;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_code     = 3'd0;
    in_accum    = 1'b0;
    clr         = 1'b0;
    out_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid",  {7'd0, out_valid}, 8'h00);
    checkOutput("rst_onehot", out_onehot,        8'h00);
    checkOutput("rst_mask",   out_mask,          8'h00);
    checkOutput("rst_dup",    {7'd0, out_dup},   8'h00);
    checkOutput("rst_full",   {7'd0, out_full},  8'h00);
    checkOutput("rst_ready",  {7'd0, in_ready},  8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] sweep codes 0..7, replace mode");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), 1'b0, 1'b0, 1'b1);
      checkOutput("sweep_valid",  {7'd0, out_valid}, 8'h01);
      checkOutput("sweep_onehot", out_onehot,        8'h01 << i);
      checkOutput("sweep_mask",   out_mask,          8'h01 << i);
      checkOutput("sweep_full",   {7'd0, out_full},  8'h00);
    end

    $display("[TB] accumulate to full");
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("acc0_mask", out_mask, 8'h01);
    for (int i = 1; i < 8; i++) begin
      applyStimulus(1'b1, 3'(i), 1'b1, 1'b0, 1'b1);
      exp_mask = 8'((2 << i) - 1);
      checkOutput("acc_mask", out_mask,          exp_mask);
      checkOutput("acc_dup",  {7'd0, out_dup},   8'h00);
      checkOutput("acc_full", {7'd0, out_full},  (i == 7) ? 8'h01 : 8'h00);
    end
    applyStimulus(1'b1, 3'd3, 1'b1, 1'b0, 1'b1);
    checkOutput("acc9_dup",  {7'd0, out_dup},  8'h01);
    checkOutput("acc9_mask", out_mask,         8'hFF);
    checkOutput("acc9_full", {7'd0, out_full}, 8'h01);

    $display("[TB] clear interactions");
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    checkOutput("clr_mask",   out_mask,                        8'h00);
    checkOutput("clr_full",   {7'd0, out_full},                8'h00);
    checkOutput("clr_state",  {6'd0, dut.state_q},             {6'd0, EMPTY});
    checkOutput("clr_valid",  {7'd0, out_valid},               8'h00);
    checkOutput("clr_onehot", out_onehot,                      8'h08);
    checkOutput("clr_dup",    {7'd0, out_dup},                 8'h01);
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0, 1'b1);
    checkOutput("pre_clr_mask", out_mask, 8'h02);
    applyStimulus(1'b1, 3'd6, 1'b1, 1'b1, 1'b1);
    checkOutput("clracc_mask",   out_mask,        8'h40);
    checkOutput("clracc_onehot", out_onehot,      8'h40);
    checkOutput("clracc_dup",    {7'd0, out_dup}, 8'h00);

    $display("[TB] duplicate detection");
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 3'd4, 1'b1, 1'b0, 1'b1);
    checkOutput("dup1_dup",  {7'd0, out_dup}, 8'h00);
    checkOutput("dup1_mask", out_mask,        8'h10);
    applyStimulus(1'b1, 3'd4, 1'b1, 1'b0, 1'b1);
    checkOutput("dup2_dup",  {7'd0, out_dup}, 8'h01);
    checkOutput("dup2_mask", out_mask,        8'h10);
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b0, 1'b1);
    checkOutput("dup3_dup",  {7'd0, out_dup}, 8'h00);
    checkOutput("dup3_mask", out_mask,        8'h10);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 3'd5, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_onehot", out_onehot, 8'h20);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
      checkOutput("bp_hold_valid",  {7'd0, out_valid}, 8'h01);
      checkOutput("bp_hold_onehot", out_onehot,        8'h20);
      checkOutput("bp_hold_mask",   out_mask,          8'h20);
      checkOutput("bp_hold_ready",  {7'd0, in_ready},  8'h00);
    end
    applyStimulus(1'b1, 3'd2, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_rel_valid",  {7'd0, out_valid}, 8'h01);
    checkOutput("bp_rel_onehot", out_onehot,        8'h04);
    checkOutput("bp_rel_mask",   out_mask,          8'h04);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_drain_valid", {7'd0, out_valid}, 8'h00);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b1, 3'd3, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("mid_pre_valid", {7'd0, out_valid}, 8'h01);
    checkOutput("mid_pre_mask",  out_mask,          8'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_valid",  {7'd0, out_valid}, 8'h00);
    checkOutput("mid_onehot", out_onehot,        8'h00);
    checkOutput("mid_mask",   out_mask,          8'h00);
    checkOutput("mid_dup",    {7'd0, out_dup},   8'h00);
    checkOutput("mid_full",   {7'd0, out_full},  8'h00);
    checkOutput("mid_ready",  {7'd0, in_ready},  8'h01);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, 3'd1, 1'b1, 1'b0, 1'b1);
    checkOutput("post_mask",   out_mask,          8'h02);
    checkOutput("post_onehot", out_onehot,        8'h02);
    checkOutput("post_dup",    {7'd0, out_dup},   8'h00);
    checkOutput("post_valid",  {7'd0, out_valid}, 8'h01);
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_stream.md
# onehot_decoder_stream

Streaming 3-to-8 decoder: the inverse of the team's 8-to-3 priority encoder. It accepts 3-bit line codes on a valid/ready input stream and emits registered one-hot words on a valid/ready output stream. It also keeps an accumulated line mask with duplicate and full detection. It sits downstream of encoder-based arbiters and turns grant indices back into per-line enables and coverage masks.

## Interface

Parameters:
- CODE_W, 3, width of the input code.
- NUM_LINES, 1<<CODE_W (8), width of the one-hot and mask outputs. Derived; not overridden independently.

Ports:
- clk  input  1  single clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  input code is valid.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  CODE_W  line index, 0..NUM_LINES-1.
- in_accum  input  1  sampled with the code: 1 ORs the line into the mask, 0 replaces the mask.
- clr  input  1  synchronous clear of the accumulated mask.
- out_valid  output  1  output beat is valid.
- out_ready  input  1  downstream accepts the beat.
- out_onehot  output  NUM_LINES  decoded word, 1<<code.
- out_mask  output  NUM_LINES  accumulated mask after this beat.
- out_dup  output  1  the beat's line was already set in the mask before this beat.
- out_full  output  1  out_mask is all ones.

## Operation

- Accept rule: accept = in_valid && in_ready, with in_ready = !out_valid || out_ready.
  - in_ready is combinational from registered out_valid and out_ready.
  - There is no path from in_valid to in_ready.
- On accept:
  - out_onehot <= 1<<in_code.
  - out_valid <= 1.
  - The mask register updates and out_dup is computed (see below).
- Without accept, if out_ready is high, out_valid <= 0. Data registers hold their last values.
- Mask update on accept:
  - in_accum=0: mask <= onehot.
  - in_accum=1: mask <= mask | onehot.
- out_dup = in_accum && mask[in_code], using the pre-update mask. It is 0 when in_accum=0.
- clr without accept: mask <= 0. out_valid, out_onehot and out_dup are unaffected.
- clr with accept in the same cycle: clear first, then apply the beat.
  - Result: mask <= onehot for either value of in_accum.
  - out_dup = 0.
- Mask FSM, state register tracking mask population:
  - EMPTY (mask==0) -> PARTIAL on accept.
  - PARTIAL -> FULL when the update makes the mask all ones.
  - PARTIAL -> EMPTY on clr without accept.
  - FULL -> PARTIAL on accept with in_accum=0.
  - FULL -> EMPTY on clr without accept.
  - FULL stays FULL on accept with in_accum=1; out_dup=1 is guaranteed in this case.
  - out_full is a direct decode of state==FULL.
- The mask is not gated by out_ready. It reflects the most recently accepted beat, and out_mask is presented with that beat.
- in_code is always within range (CODE_W bits cover all 8 lines), so no error path exists.

## Timing

- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: 1 beat/cycle while out_ready=1.
- Backpressure:
  - While out_valid=1 and out_ready=0, all outputs are held stable and in_ready=0.
  - A beat whose input handshake completes is never dropped.
- Simultaneous accept and output-consume in one cycle: the new beat replaces the old one with no bubble.
- Reset values (asynchronous assert, synchronous deassert edge):
  - out_valid=0, out_onehot=0, out_mask=0, out_dup=0, out_full=0.
  - FSM=EMPTY.
  - in_ready=1 as a consequence of out_valid=0.
- Reset mid-stream: a pending output beat is discarded and the mask is cleared. The first accept after reset sees an EMPTY mask.

## Structure

- Package onehot_dec_pkg holds:
  - localparams CODE_W=3 and NUM_LINES=8.
  - typedefs code_t (logic [CODE_W-1:0]) and line_t (logic [NUM_LINES-1:0]).
  - enum mask_state_e {EMPTY, PARTIAL, FULL}.
- Sub-module code_to_onehot: purely combinational, code_t in, line_t out. It is reused by the arbiter bench models.
- Top level contains the output register stage, the mask register and the FSM. Target size is roughly 150-250 lines.

## Test plan

- Sweep: codes 0..7 back-to-back, in_accum=0, out_ready=1.
  - out_onehot = 8'h01, 02, 04 … 80 on consecutive cycles.
  - out_mask equals out_onehot each beat; out_full stays 0.
- Accumulate to full: codes 0..7 with in_accum=1.
  - out_mask progresses 01, 03, 07 … FF.
  - out_full=1 on the 8th beat.
  - A 9th beat with code 3 gives out_dup=1, out_mask=FF, out_full=1.
- Backpressure: hold out_ready=0 for 3 cycles after code 5 is accepted.
  - out_onehot=8'h20 is held stable and in_ready=0.
  - On release, the queued code 2 follows the next cycle with no loss.
- Clear interactions:
  - From mask=FF, clr alone gives mask=00 and FSM EMPTY.
  - clr together with an accept of code 6 (in_accum=1) gives out_mask=8'h40, out_dup=0.
- Duplicate detection: sequence 4, 4 with in_accum=1.
  - Second beat: out_dup=1, out_mask=8'h10.
  - Then code 4 with in_accum=0: out_dup=0.
- Reset mid-stream: assert rst_n=0 while out_valid=1 and out_ready=0, mask=8'h0F.
  - All outputs go to 0 immediately and in_ready=1.
  - After reset, code 1 with in_accum=1 gives out_mask=8'h02.
